// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Pipelined immediate-extension unit (zero / sign / branch-offset
//               / upper-immediate) with a valid/ready stage backed by a
//               2-entry skid buffer and a pass-through tag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_neg
);

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_BR    = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    // State encoding mirrors the storage valid bits: bit1 = main, bit0 = skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [OUT_W-1:0]    main_data_q, main_data_d;
    logic [TAG_W-1:0]    main_tag_q,  main_tag_d;
    logic [OUT_W-1:0]    skid_data_q, skid_data_d;
    logic [TAG_W-1:0]    skid_tag_q,  skid_tag_d;

    logic [OUT_W-1:0]    zx_val;
    logic [OUT_W-1:0]    sx_val;
    logic [OUT_W-1:0]    ext_val;
    logic                accept;
    logic                xfer;

    // Handshake flags; both depend only on registered state plus the peer's strobe.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign out_neg   = main_data_q[OUT_W-1];

    // Extend the incoming immediate according to the requested mode.
    always_comb begin
        zx_val = OUT_W'(in_imm);
        sx_val = OUT_W'($signed(in_imm));
        ext_val = zx_val;
        case (in_mode)
            MODE_ZERO:  ext_val = zx_val;
            MODE_SIGN:  ext_val = sx_val;
            MODE_BR:    ext_val = sx_val << BR_SHIFT;
            MODE_UPPER: ext_val = zx_val << (OUT_W - IN_W);
            default:    ext_val = zx_val;
        endcase
    end

    // Next-state and storage update for the main/skid pair.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = ext_val;
                    main_tag_d  = in_tag;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_data_d = ext_val;
                    main_tag_d  = in_tag;
                end else if (accept) begin
                    skid_data_d = ext_val;
                    skid_tag_d  = in_tag;
                    state_d     = ST_FULL;
                end else if (xfer) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (xfer) begin
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State and storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Directed self-checking bench for imm_extend_pipe (default and
//               6-to-8-bit configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;

    // Default-parameter instance signals
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_neg;

    // 6-to-8-bit instance signals
    logic        n_in_valid;
    logic        n_in_ready;
    logic [5:0]  n_in_imm;
    logic [1:0]  n_in_mode;
    logic [3:0]  n_in_tag;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [7:0]  n_out_data;
    logic [3:0]  n_out_tag;
    logic        n_out_neg;

    int checks;
    int errors;

    imm_extend_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_neg   (out_neg)
    );

    imm_extend_pipe #(
        .IN_W     (6),
        .OUT_W    (8),
        .BR_SHIFT (2),
        .TAG_W    (4)
    ) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_imm    (n_in_imm),
        .in_mode   (n_in_mode),
        .in_tag    (n_in_tag),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .out_tag   (n_out_tag),
        .out_neg   (n_out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference extension for the default 16->32 configuration.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            2'b00:   ref_ext = {16'h0000, imm};
            2'b01:   ref_ext = {{16{imm[15]}}, imm};
            2'b10:   ref_ext = {{14{imm[15]}}, imm, 2'b00};
            default: ref_ext = {imm, 16'h0000};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            out_tag !== 4'h0 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b data=%h tag=%h neg=%b required 0 1 00000000 0 0",
                     out_valid, in_ready, out_data, out_tag, out_neg);
        end
        checks++;
        if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1 || n_out_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_narrow: valid=%b ready=%b data=%h required 0 1 00",
                     n_out_valid, n_in_ready, n_out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h00008004;
        exp_tab[1] = 32'hFFFF8004;
        exp_tab[2] = 32'hFFFE0010;
        exp_tab[3] = 32'h80040000;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            in_imm   = 16'h8004;
            in_mode  = 2'(m);
            in_tag   = 4'(m + 8);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[m] || out_tag !== 4'(m + 8) ||
                out_neg !== exp_tab[m][31]) begin
                errors++;
                $display("FAIL mode%0d: valid=%b data=%h tag=%h neg=%b required 1 %h %h %b",
                         m, out_valid, out_data, out_tag, out_neg, exp_tab[m], 4'(m + 8), exp_tab[m][31]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL modes_drain: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_narrow();
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        n_in_mode   = 2'b01;
        n_in_imm    = 6'b000111;
        n_in_tag    = 4'h1;
        tick();
        checks++;
        if (n_out_valid !== 1'b1 || n_out_data !== 8'b00000111 || n_out_neg !== 1'b0) begin
            errors++;
            $display("FAIL narrow_pos: valid=%b data=%b neg=%b required 1 00000111 0",
                     n_out_valid, n_out_data, n_out_neg);
        end
        n_in_imm = 6'b101010;
        n_in_tag = 4'h2;
        tick();
        checks++;
        if (n_out_valid !== 1'b1 || n_out_data !== 8'b11101010 || n_out_neg !== 1'b1 ||
            n_out_tag !== 4'h2) begin
            errors++;
            $display("FAIL narrow_neg: valid=%b data=%b neg=%b tag=%h required 1 11101010 1 2",
                     n_out_valid, n_out_data, n_out_neg, n_out_tag);
        end
        n_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_mode   = 2'b00;
        in_valid  = 1'b1;
        in_tag    = 4'd1;
        in_imm    = 16'h0011;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
            errors++;
            $display("FAIL bp_first: ready=%b valid=%b tag=%h required 1 1 1", in_ready, out_valid, out_tag);
        end
        in_tag = 4'd2;
        in_imm = 16'h0022;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_data !== 32'h11) begin
            errors++;
            $display("FAIL bp_full: ready=%b tag=%h data=%h required 0 1 00000011", in_ready, out_tag, out_data);
        end
        in_tag = 4'd3;
        in_imm = 16'h0033;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_data !== 32'h11) begin
            errors++;
            $display("FAIL bp_hold: ready=%b tag=%h data=%h required 0 1 00000011", in_ready, out_tag, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_tag !== 4'd2 || out_data !== 32'h22) begin
            errors++;
            $display("FAIL bp_second: ready=%b tag=%h data=%h required 1 2 00000022", in_ready, out_tag, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_data !== 32'h33) begin
            errors++;
            $display("FAIL bp_third: valid=%b tag=%h data=%h required 1 3 00000033", out_valid, out_tag, out_data);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_mode   = 2'b00;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'(i * 3 + 1);
            in_tag   = 4'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready%0d: ready=%b required 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i * 3 + 1) || out_tag !== 4'(i)) begin
                errors++;
                $display("FAIL stream%0d: valid=%b data=%h tag=%h required 1 %h %h",
                         i, out_valid, out_data, out_tag, 32'(i * 3 + 1), 4'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [35:0] sb [$];
        logic [35:0] front;
        logic [31:0] held_data;
        logic [3:0]  held_tag;
        logic        held;
        int          sent;
        int          rcvd;
        int          cycles;
        sent   = 0;
        rcvd   = 0;
        cycles = 0;
        held   = 1'b0;
        held_data = '0;
        held_tag  = '0;
        while ((sent < 1000 || rcvd < 1000) && cycles < 10000) begin
            in_valid  = (sent < 1000) ? 1'($urandom_range(1, 0)) : 1'b0;
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(3, 0));
            in_tag    = 4'(sent);
            out_ready = 1'($urandom_range(1, 0));
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_tag !== held_tag) begin
                    errors++;
                    $display("FAIL rand_stable: valid=%b data=%h tag=%h required 1 %h %h",
                             out_valid, out_data, out_tag, held_data, held_tag);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: data=%h tag=%h required no result", out_data, out_tag);
                end else begin
                    front = sb.pop_front();
                    if (out_data !== front[35:4] || out_tag !== front[3:0]) begin
                        errors++;
                        $display("FAIL rand_order%0d: data=%h tag=%h required %h %h",
                                 rcvd, out_data, out_tag, front[35:4], front[3:0]);
                    end
                end
                rcvd++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_tag  = out_tag;
            if (in_valid && in_ready) begin
                sb.push_back({ref_ext(in_imm, in_mode), in_tag});
                sent++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 1000 || rcvd != 1000 || sb.size() != 0) begin
            errors++;
            $display("FAIL rand_count: sent=%0d rcvd=%0d left=%0d required 1000 1000 0",
                     sent, rcvd, sb.size());
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_mode   = 2'b00;
        in_valid  = 1'b1;
        in_imm    = 16'h00AA;
        in_tag    = 4'd7;
        tick();
        in_imm = 16'h00BB;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rf_full: ready=%b required 0", in_ready);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rf_reset: valid=%b ready=%b data=%h required 0 1 00000000",
                     out_valid, in_ready, out_data);
        end
        // Accept offered while reset is still held must be ignored.
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rf_ignore: valid=%b data=%h required 0 00000000", out_valid, out_data);
        end
        rst_n   = 1'b1;
        in_imm  = 16'h8004;
        in_mode = 2'b10;
        in_tag  = 4'd5;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFE0010 || out_tag !== 4'd5 || out_neg !== 1'b1) begin
            errors++;
            $display("FAIL rf_after: valid=%b data=%h tag=%h neg=%b required 1 fffe0010 5 1",
                     out_valid, out_data, out_tag, out_neg);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_imm      = '0;
        in_mode     = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        n_in_valid  = 1'b0;
        n_in_imm    = '0;
        n_in_mode   = '0;
        n_in_tag    = '0;
        n_out_ready = 1'b0;
        #1;
        test_reset();
        test_modes();
        test_narrow();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. Generalises the fixed 6-to-8-bit sign extender: configurable input/output widths, four extension modes (zero, sign, branch-offset, upper-immediate), and a registered valid/ready stage with a 2-entry skid buffer so it can sit between decode and execute without a combinational ready path. A tag rides alongside each operand so downstream logic can match results to instructions.

## Interface
- IN_W, 16, immediate field width (>= 2)
- OUT_W, 32, extended output width (>= IN_W + BR_SHIFT)
- BR_SHIFT, 2, left shift applied in branch-offset mode (0..4)
- TAG_W, 4, width of the pass-through tag
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  unit can accept an operand this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  00 zero-ext, 01 sign-ext, 10 branch offset, 11 upper immediate
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  extended value
- out_tag  out  TAG_W  tag of out_data
- out_neg  out  1  MSB of out_data

## Operation
- Extension, computed combinationally on accept, registered into storage:
  - 00: upper OUT_W-IN_W bits zero, low bits = in_imm.
  - 01: upper bits replicate in_imm[IN_W-1].
  - 10: sign-extend to OUT_W, then shift left BR_SHIFT; bits shifted past OUT_W discarded, low BR_SHIFT bits zero.
  - 11: in_imm placed at bits [OUT_W-1 : OUT_W-IN_W], remaining low bits zero.
- Storage: main register (drives out_*) and skid register; each has a valid bit.
- Accept = in_valid & in_ready. Transfer out = out_valid & out_ready.
- States (main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1); (0,1) unreachable.
  - EMPTY: accept -> ONE (load main).
  - ONE, accept & transfer -> ONE (main reloaded with new). Accept only -> FULL (load skid). Transfer only -> EMPTY. Neither -> ONE.
  - FULL: in_ready=0. Transfer -> ONE (skid moves to main). No transfer -> FULL, all held.
- in_ready = ~skid_v (pure register output, no path from out_ready).
- out_valid = main_v; out_data/out_tag/out_neg held stable while out_valid & ~out_ready.
- in_mode, in_imm, in_tag ignored when not accepted.
- Ordering strictly FIFO; no result dropped or duplicated.

## Timing
- Latency: accept at edge N -> out_valid high after edge N (visible cycle N+1) when EMPTY.
- Throughput: one result per cycle with out_ready held high.
- Reset (rst_n low at a rising edge): main_v=0, skid_v=0, out_valid=0, in_ready=1, out_data=0, out_tag=0, out_neg=0. Reset mid-operation discards both entries; accept in the reset cycle is ignored.
- in_ready falls the cycle after FULL is entered; a sender may rely on in_ready sampled at the same edge.
- Simultaneous accept and transfer in ONE never stalls.

## Test plan
- IN_W=6, OUT_W=8, mode 01: in_imm 6'b000111 -> 8'b00000111; 6'b101010 -> 8'b11101010, out_neg=1, one cycle after accept.
- Defaults, all modes with in_imm 16'h8004: 00 -> 32'h00008004; 01 -> 32'hFFFF8004; 10 -> 32'hFFFE0010; 11 -> 32'h80040000.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back -> tags 1,2 stored, in_ready=0 from cycle after second accept, tag 3 held by sender; release out_ready -> out_tag order 1,2,3, no loss.
- Streaming: out_ready=1, 20 consecutive operands -> 20 results, one per cycle, in_ready never low.
- Random in_valid/out_ready toggling, 1000 operands -> scoreboard matches values and order; out_data stable whenever out_valid & ~out_ready.
- Reset while FULL -> next cycle out_valid=0, in_ready=1, out_data=0; following accept returns correct result.
